// File: rtl/sscd.sv
// Serial 1-0-1-1-0 detector: registered match pulse one cycle after the accepting bit,
// saturating match counter, sticky flag and a 5-bit LED shift view; no backpressure, din_valid strobes bits.
module sscd #(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clr,
    output logic             match,
    output logic             sticky,
    output logic [CNT_W-1:0] match_cnt,
    output logic [2:0]       state_o,
    output logic [4:0]       Led
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_101  = 3'd3,
        S_1011 = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             hit_d;
    logic             match_q;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       led_q, led_d;

    always_comb begin
        state_d = state_q;
        hit_d   = 1'b0;
        case (state_q)
            S_IDLE: if (din_valid) state_d = din ? S_1 : S_IDLE;
            S_1:    if (din_valid) state_d = din ? S_1 : S_10;
            S_10:   if (din_valid) state_d = din ? S_101 : S_IDLE;
            S_101:  if (din_valid) state_d = din ? S_1011 : S_10;
            S_1011: begin
                if (din_valid) begin
                    if (din) begin
                        state_d = S_1;
                    end else begin
                        // Overlap keeps the trailing "10" of the match as a fresh prefix.
                        hit_d   = 1'b1;
                        state_d = (OVERLAP != 0) ? S_10 : S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (clr) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (hit_d) begin
            sticky_d = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
        led_d = din_valid ? {led_q[3:0], din} : led_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            match_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            led_q    <= 5'd0;
        end else begin
            state_q  <= state_d;
            match_q  <= hit_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
        end
    end

    assign match     = match_q;
    assign sticky    = sticky_q;
    assign match_cnt = cnt_q;
    assign state_o   = state_q;
    assign Led       = led_q;

endmodule

// File: tb/tb_sscd.sv
// Bench for sscd: three instances (overlap/cnt8, no-overlap/cnt8, overlap/cnt2) share one stimulus
// and are checked against a bit-history reference model.
module tb_sscd;

    logic clk, rst_n, din_valid, din, clr;
    logic [2:0] match_w, sticky_w;
    logic [2:0] st_w [3];
    logic [4:0] led_w [3];
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic [7:0] cntv [3];

    assign cntv[0] = cnt0;
    assign cntv[1] = cnt1;
    assign cntv[2] = {6'd0, cnt2};

    sscd #(.OVERLAP(1), .CNT_W(8)) u_ov1 (.clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr(clr),
        .match(match_w[0]), .sticky(sticky_w[0]), .match_cnt(cnt0), .state_o(st_w[0]), .Led(led_w[0]));
    sscd #(.OVERLAP(0), .CNT_W(8)) u_ov0 (.clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr(clr),
        .match(match_w[1]), .sticky(sticky_w[1]), .match_cnt(cnt1), .state_o(st_w[1]), .Led(led_w[1]));
    sscd #(.OVERLAP(1), .CNT_W(2)) u_sat (.clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .clr(clr),
        .match(match_w[2]), .sticky(sticky_w[2]), .match_cnt(cnt2), .state_o(st_w[2]), .Led(led_w[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam int PAT = 22; // 1-0-1-1-0, first bit in MSB
    int ov_p   [3] = '{1, 0, 1};
    int cmax_p [3] = '{255, 255, 3};

    // Reference model: window of recent bits since the last restart point.
    int   win [3];
    int   nbit [3];
    bit   exp_match [3];
    int   exp_cnt [3];
    bit   exp_sticky [3];
    int   exp_state [3];
    logic [4:0] exp_led;

    int n_vec, n_err;

    function automatic int prefix_len(input int w, input int n);
        for (int k = 4; k >= 1; k--)
            if (n >= k && ((w & ((1 << k) - 1)) == (PAT >> (5 - k)))) return k;
        return 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            win[i] = 0; nbit[i] = 0; exp_match[i] = 0;
            exp_cnt[i] = 0; exp_sticky[i] = 0; exp_state[i] = 0;
        end
        exp_led = 5'd0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit c);
        for (int i = 0; i < 3; i++) begin
            exp_match[i] = 0;
            if (v) begin
                win[i]  = ((win[i] << 1) | int'(b)) & 31;
                nbit[i] = (nbit[i] < 5) ? nbit[i] + 1 : 5;
                if (nbit[i] == 5 && win[i] == PAT) begin
                    exp_match[i] = 1;
                    if (ov_p[i] == 0) begin win[i] = 0; nbit[i] = 0; end
                end
            end
            if (c) begin
                exp_cnt[i] = 0; exp_sticky[i] = 0;
            end else if (exp_match[i]) begin
                exp_sticky[i] = 1;
                if (exp_cnt[i] < cmax_p[i]) exp_cnt[i]++;
            end
            exp_state[i] = prefix_len(win[i], nbit[i]);
        end
        if (v) exp_led = {exp_led[3:0], b};
    endtask

    // Drives one cycle of inputs and advances the model; outputs are stable after return.
    task automatic apply(input bit v, input bit b, input bit c);
        @(negedge clk);
        din_valid = v; din = b; clr = c;
        model_step(v, b, c);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; din_valid = 1'b0; din = 1'b0; clr = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        for (int i = 0; i < 3; i++) begin
            n_vec += 5;
            if (match_w[i] !== 1'b0) begin n_err++; $display("FAIL reset_match[%0d] got %b want 0", i, match_w[i]); end
            if (sticky_w[i] !== 1'b0) begin n_err++; $display("FAIL reset_sticky[%0d] got %b want 0", i, sticky_w[i]); end
            if (cntv[i] !== 8'd0) begin n_err++; $display("FAIL reset_cnt[%0d] got %0d want 0", i, cntv[i]); end
            if (st_w[i] !== 3'd0) begin n_err++; $display("FAIL reset_state[%0d] got %0d want 0", i, st_w[i]); end
            if (led_w[i] !== 5'd0) begin n_err++; $display("FAIL reset_led[%0d] got %b want 0", i, led_w[i]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_stream();
        logic [15:0] stream;
        int pulses;
        stream = 16'h0D95;
        pulses = 0;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int idx = 0; idx < 16; idx++) begin
                apply(1'b1, stream[15 - idx], 1'b0);
                n_vec += 2;
                if (match_w[0]) pulses++;
                if (match_w[0] !== (idx == 9)) begin
                    n_err++; $display("FAIL stream_pulse p%0d i%0d got %b want %b", p, idx, match_w[0], idx == 9);
                end
                if (match_w[1] !== exp_match[1]) begin
                    n_err++; $display("FAIL stream_nov p%0d i%0d got %b want %b", p, idx, match_w[1], exp_match[1]);
                end
            end
        end
        n_vec += 4;
        if (pulses != 3) begin n_err++; $display("FAIL stream_pulses got %0d want 3", pulses); end
        if (cnt0 !== 8'd3) begin n_err++; $display("FAIL stream_cnt got %0d want 3", cnt0); end
        if (cnt1 !== 8'd3) begin n_err++; $display("FAIL stream_cnt_nov got %0d want 3", cnt1); end
        if (sticky_w[0] !== 1'b1) begin n_err++; $display("FAIL stream_sticky got %b want 1", sticky_w[0]); end
    endtask

    task automatic test_overlap();
        logic [7:0] bits;
        bits = 8'b1011_0110;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, bits[7 - i], 1'b0);
            n_vec += 2;
            if (match_w[0] !== (i == 4 || i == 7)) begin
                n_err++; $display("FAIL overlap_ov1 bit%0d got %b want %b", i, match_w[0], (i == 4 || i == 7));
            end
            if (match_w[1] !== (i == 4)) begin
                n_err++; $display("FAIL overlap_ov0 bit%0d got %b want %b", i, match_w[1], i == 4);
            end
        end
        n_vec += 2;
        if (cnt0 !== 8'd2) begin n_err++; $display("FAIL overlap_cnt_ov1 got %0d want 2", cnt0); end
        if (cnt1 !== 8'd1) begin n_err++; $display("FAIL overlap_cnt_ov0 got %0d want 1", cnt1); end
    endtask

    task automatic test_gap();
        int pulses;
        pulses = 0;
        do_reset();
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        for (int g = 0; g < 7; g++) begin
            apply(1'b0, g[0], 1'b0);
            n_vec += 2;
            if (st_w[0] !== 3'd3) begin n_err++; $display("FAIL gap_state cyc%0d got %0d want 3", g, st_w[0]); end
            if (match_w[0] !== 1'b0) begin n_err++; $display("FAIL gap_match cyc%0d got %b want 0", g, match_w[0]); end
        end
        apply(1'b1, 1'b1, 1'b0);
        if (match_w[0]) pulses++;
        apply(1'b1, 1'b0, 1'b0);
        if (match_w[0]) pulses++;
        n_vec += 3;
        if (match_w[0] !== 1'b1) begin n_err++; $display("FAIL gap_final_match got %b want 1", match_w[0]); end
        if (pulses != 1) begin n_err++; $display("FAIL gap_pulses got %0d want 1", pulses); end
        if (led_w[0] !== 5'b10110) begin n_err++; $display("FAIL gap_led got %b want 10110", led_w[0]); end
    endtask

    task automatic test_saturate();
        int want [5] = '{1, 2, 3, 3, 3};
        logic [4:0] pat;
        pat = 5'b10110;
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 5; i++) apply(1'b1, pat[4 - i], 1'b0);
            n_vec += 2;
            if (match_w[2] !== 1'b1) begin n_err++; $display("FAIL sat_pulse r%0d got %b want 1", r, match_w[2]); end
            if (cnt2 !== want[r][1:0]) begin n_err++; $display("FAIL sat_cnt r%0d got %0d want %0d", r, cnt2, want[r]); end
            apply(1'b0, 1'b0, 1'b0);
            apply(1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_clr();
        logic [4:0] pat;
        pat = 5'b10110;
        do_reset();
        for (int i = 0; i < 4; i++) apply(1'b1, pat[4 - i], 1'b0);
        apply(1'b1, 1'b0, 1'b1);
        n_vec += 3;
        if (match_w[0] !== 1'b1) begin n_err++; $display("FAIL clr_match got %b want 1", match_w[0]); end
        if (cnt0 !== 8'd0) begin n_err++; $display("FAIL clr_cnt got %0d want 0", cnt0); end
        if (sticky_w[0] !== 1'b0) begin n_err++; $display("FAIL clr_sticky got %b want 0", sticky_w[0]); end
        for (int i = 0; i < 5; i++) apply(1'b1, pat[4 - i], 1'b0);
        n_vec += 2;
        if (cnt0 !== 8'd1) begin n_err++; $display("FAIL clr_next_cnt got %0d want 1", cnt0); end
        if (sticky_w[0] !== 1'b1) begin n_err++; $display("FAIL clr_next_sticky got %b want 1", sticky_w[0]); end
    endtask

    task automatic test_midreset();
        logic [4:0] pat;
        pat = 5'b10110;
        do_reset();
        for (int i = 0; i < 4; i++) apply(1'b1, pat[4 - i], 1'b0);
        n_vec += 1;
        if (st_w[0] !== 3'd4) begin n_err++; $display("FAIL midrst_pre_state got %0d want 4", st_w[0]); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec += 4;
        if (st_w[0] !== 3'd0) begin n_err++; $display("FAIL midrst_state got %0d want 0", st_w[0]); end
        if (led_w[0] !== 5'd0) begin n_err++; $display("FAIL midrst_led got %b want 0", led_w[0]); end
        if (match_w[0] !== 1'b0) begin n_err++; $display("FAIL midrst_match got %b want 0", match_w[0]); end
        if (cnt0 !== 8'd0 || sticky_w[0] !== 1'b0) begin
            n_err++; $display("FAIL midrst_cnt_sticky got %0d/%b want 0/0", cnt0, sticky_w[0]);
        end
        @(negedge clk);
        rst_n = 1'b1; din_valid = 1'b0; clr = 1'b0;
        model_clear();
        apply(1'b1, 1'b0, 1'b0);
        n_vec += 1;
        if (match_w[0] !== 1'b0) begin n_err++; $display("FAIL midrst_zero_match got %b want 0", match_w[0]); end
        for (int i = 0; i < 5; i++) apply(1'b1, pat[4 - i], 1'b0);
        n_vec += 1;
        if (match_w[0] !== 1'b1) begin n_err++; $display("FAIL midrst_full_match got %b want 1", match_w[0]); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            apply($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 40) == 0);
            for (int i = 0; i < 3; i++) begin
                n_vec += 5;
                if (match_w[i] !== exp_match[i]) begin
                    n_err++; $display("FAIL rnd_match[%0d] c%0d got %b want %b", i, c, match_w[i], exp_match[i]);
                end
                if (cntv[i] !== 8'(exp_cnt[i])) begin
                    n_err++; $display("FAIL rnd_cnt[%0d] c%0d got %0d want %0d", i, c, cntv[i], exp_cnt[i]);
                end
                if (sticky_w[i] !== exp_sticky[i]) begin
                    n_err++; $display("FAIL rnd_sticky[%0d] c%0d got %b want %b", i, c, sticky_w[i], exp_sticky[i]);
                end
                if (st_w[i] !== 3'(exp_state[i])) begin
                    n_err++; $display("FAIL rnd_state[%0d] c%0d got %0d want %0d", i, c, st_w[i], exp_state[i]);
                end
                if (led_w[i] !== exp_led) begin
                    n_err++; $display("FAIL rnd_led[%0d] c%0d got %b want %b", i, c, led_w[i], exp_led);
                end
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; din_valid = 1'b0; din = 1'b0; clr = 1'b0;
        model_clear();
        test_reset();
        test_stream();
        test_overlap();
        test_gap();
        test_saturate();
        test_clr();
        test_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
